// File: rtl/mem_stage_sb_if.sv
// Data-memory request/response bus of the MEM stage.
// The stage drives it as master; the data memory answers as slave.
interface mem_stage_sb_if #(
    parameter int XLEN = 32
);
    logic            MEM_REQ;
    logic            MEM_WE;
    logic [XLEN-1:0] MEM_ADDR;
    logic [XLEN-1:0] MEM_WDATA;
    logic [2:0]      MEM_FUNC3;
    logic [XLEN-1:0] MEM_RDATA;
    logic            MEM_ACK;

    modport master (
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_FUNC3,
        input  MEM_RDATA, MEM_ACK
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_FUNC3,
        output MEM_RDATA, MEM_ACK
    );
endinterface

// File: rtl/mem_stage_sb.sv
// RV32 MEM stage with a FIFO store buffer, load priority over draining and load/store address hazard stall.
// Define MEM_STAGE_SB_BYPASS_EN to let a load take data from the youngest identical-address buffered SW.
module mem_stage_sb #(
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       MEM_READ_EN_EXMEM,
    input  logic                       MEM_WRITE_EN_EXMEM,
    input  logic [2:0]                 FUNC3_EXMEM,
    input  logic [XLEN-1:0]            RESULT,
    input  logic [XLEN-1:0]            REG_DATA_2_EXMEM,
    input  logic [4:0]                 RS2_ADDR_EXMEM,
    input  logic                       REG_WRITE_EN_WB,
    input  logic [4:0]                 REG_WRITE_ADDR_WB,
    input  logic [XLEN-1:0]            WB_DATA,
    mem_stage_sb_if.master             mem,
    output logic [XLEN-1:0]            READ_DATA,
    output logic                       MEM_BUSYWAIT,
    output logic [$clog2(SB_DEPTH):0]  SB_COUNT
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] sb_addr_q  [SB_DEPTH];
    logic [XLEN-1:0] sb_data_q  [SB_DEPTH];
    logic [2:0]      sb_func3_q [SB_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [2:0]      mem_func3_q, mem_func3_d;
    logic [XLEN-1:0] read_data_q, read_data_d;
    logic            load_done_q, load_done_d;

    logic [SB_DEPTH-1:0] entry_valid, entry_match;
    logic                hazard, sb_full, do_enq, do_pop, load_pending, bypass_hit;
    logic [XLEN-1:0]     store_data, bypass_data;

    function automatic logic [XLEN-1:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                                     input logic [XLEN-1:0] word);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   r = {{(XLEN-8){b[7]}}, b};
            F3_LH:   r = {{(XLEN-16){h[15]}}, h};
            F3_LBU:  r = {{(XLEN-8){1'b0}}, b};
            F3_LHU:  r = {{(XLEN-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Entry validity comes from its age relative to the read pointer.
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_entry
        logic [PW-1:0] age;
        assign age             = PW'(gi) - rd_ptr_q;
        assign entry_valid[gi] = CW'(age) < count_q;
        assign entry_match[gi] = entry_valid[gi] && (sb_addr_q[gi][XLEN-1:2] == RESULT[XLEN-1:2]);
    end

    assign hazard       = |entry_match;
    assign sb_full      = (count_q == CW'(SB_DEPTH));
    assign do_enq       = MEM_WRITE_EN_EXMEM && !sb_full;
    assign load_pending = MEM_READ_EN_EXMEM && !load_done_q;
    assign store_data   = (REG_WRITE_EN_WB && (REG_WRITE_ADDR_WB == RS2_ADDR_EXMEM) && (RS2_ADDR_EXMEM != 5'd0))
                          ? WB_DATA : REG_DATA_2_EXMEM;

`ifdef MEM_STAGE_SB_BYPASS_EN
    logic [PW-1:0] scan_idx, young_idx;
    logic          young_found;

    // Scan oldest to youngest so the last hit is the youngest match.
    always_comb begin
        scan_idx    = rd_ptr_q;
        young_idx   = rd_ptr_q;
        young_found = 1'b0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            scan_idx = rd_ptr_q + PW'(k);
            if (entry_match[scan_idx]) begin
                young_idx   = scan_idx;
                young_found = 1'b1;
            end
        end
    end

    assign bypass_hit  = load_pending && (state_q != LOAD) && young_found
                         && (sb_func3_q[young_idx] == F3_LW) && (sb_addr_q[young_idx] == RESULT);
    assign bypass_data = extend_load(FUNC3_EXMEM, RESULT[1:0], sb_data_q[young_idx]);
`else
    assign bypass_hit  = 1'b0;
    assign bypass_data = '0;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_func3_d = mem_func3_q;
        read_data_d = read_data_q;
        load_done_d = 1'b0;
        do_pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_pending && !hazard) begin
                    state_d     = LOAD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = RESULT;
                    mem_wdata_d = '0;
                    mem_func3_d = FUNC3_EXMEM;
                end else if (count_q != '0) begin
                    state_d     = DRAIN;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = sb_addr_q[rd_ptr_q];
                    mem_wdata_d = sb_data_q[rd_ptr_q];
                    mem_func3_d = sb_func3_q[rd_ptr_q];
                end
            end
            DRAIN: begin
                if (mem.MEM_ACK) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    do_pop    = 1'b1;
                end
            end
            LOAD: begin
                if (mem.MEM_ACK) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    read_data_d = extend_load(mem_func3_q, mem_addr_q[1:0], mem.MEM_RDATA);
                    load_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bypass_hit) begin
            read_data_d = bypass_data;
            load_done_d = 1'b1;
        end

        if (do_enq) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(do_enq) - CW'(do_pop);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_func3_q <= '0;
            read_data_q <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_func3_q <= mem_func3_d;
            read_data_q <= read_data_d;
            load_done_q <= load_done_d;
        end
    end

    // Payload storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (do_enq) begin
            sb_addr_q[wr_ptr_q]  <= RESULT;
            sb_data_q[wr_ptr_q]  <= store_data;
            sb_func3_q[wr_ptr_q] <= FUNC3_EXMEM;
        end
    end

    assign mem.MEM_REQ   = mem_req_q;
    assign mem.MEM_WE    = mem_we_q;
    assign mem.MEM_ADDR  = mem_addr_q;
    assign mem.MEM_WDATA = mem_wdata_q;
    assign mem.MEM_FUNC3 = mem_func3_q;
    assign READ_DATA     = read_data_q;
    assign SB_COUNT      = count_q;
    assign MEM_BUSYWAIT  = RESET && (load_pending || (MEM_WRITE_EN_EXMEM && sb_full));
endmodule

// File: tb/tb_mem_stage_sb.sv
// Self-checking bench for mem_stage_sb: vector table plus hand-written multi-cycle sequences,
// with a memory responder that scores drained stores against a queue of expected stores.
module tb_mem_stage_sb;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rd_en, wr_en, wb_en;
    logic [2:0]  f3;
    logic [31:0] result, rdata2, wb_data;
    logic [4:0]  rs2, wb_addr;
    logic [31:0] read_data;
    logic        busy;
    logic [2:0]  sb_count;

    mem_stage_sb_if #(.XLEN(XLEN)) mem_if ();

    mem_stage_sb #(.XLEN(XLEN), .SB_DEPTH(4)) dut (
        .CLK               (clk),
        .RESET             (rst_n),
        .MEM_READ_EN_EXMEM (rd_en),
        .MEM_WRITE_EN_EXMEM(wr_en),
        .FUNC3_EXMEM       (f3),
        .RESULT            (result),
        .REG_DATA_2_EXMEM  (rdata2),
        .RS2_ADDR_EXMEM    (rs2),
        .REG_WRITE_EN_WB   (wb_en),
        .REG_WRITE_ADDR_WB (wb_addr),
        .WB_DATA           (wb_data),
        .mem               (mem_if.master),
        .READ_DATA         (read_data),
        .MEM_BUSYWAIT      (busy),
        .SB_COUNT          (sb_count)
    );

    typedef struct {
        bit          is_load;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rs2;
        bit          wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
    } st_t;

    int          compared   = 0;
    int          mismatched = 0;
    st_t         exp_st_q [$];
    logic [31:0] exp_ld_q [$];
    logic [32:0] ops_q    [$];
    logic [31:0] mem_words [logic [29:0]];
    bit          ack_en = 1'b1;
    bit          resp_manual = 1'b0;
    int          ack_lat = 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input bit ld, input logic [2:0] fc, input logic [31:0] a, input logic [31:0] d,
                                input logic [4:0] r2, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [31:0] e);
        vec_t v;
        v.is_load = ld; v.f3 = fc; v.addr = a; v.data = d; v.rs2 = r2;
        v.wb_en = we; v.wb_addr = wa; v.wb_data = wd; v.exp = e;
        return v;
    endfunction

    function automatic void mem_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] fc);
        logic [31:0] w;
        w = mem_words.exists(a[31:2]) ? mem_words[a[31:2]] : 32'h0;
        case (fc[1:0])
            2'b00:   w[{a[1:0], 3'b000} +: 8]  = d[7:0];
            2'b01:   w[{a[1], 4'b0000} +: 16] = d[15:0];
            default: w = d;
        endcase
        mem_words[a[31:2]] = w;
    endfunction

    // Memory responder: acks after ack_lat request cycles, scores each drained store.
    initial begin
        int          wait_cnt;
        logic [31:0] cap_addr, cap_wdata;
        st_t         e;
        wait_cnt = 0; cap_addr = '0; cap_wdata = '0;
        mem_if.MEM_ACK   = 1'b0;
        mem_if.MEM_RDATA = '0;
        forever begin
            @(negedge clk);
            if (!resp_manual) begin
                mem_if.MEM_ACK = 1'b0;
                if (!mem_if.MEM_REQ) begin
                    wait_cnt = 0;
                end else if (ack_en) begin
                    if (wait_cnt == 0) begin
                        cap_addr  = mem_if.MEM_ADDR;
                        cap_wdata = mem_if.MEM_WDATA;
                    end
                    wait_cnt++;
                    if (wait_cnt >= ack_lat) begin
                        chk("req_stable", {mem_if.MEM_ADDR, mem_if.MEM_WDATA}, {cap_addr, cap_wdata});
                        mem_if.MEM_ACK = 1'b1;
                        wait_cnt = 0;
                        ops_q.push_back({mem_if.MEM_WE, mem_if.MEM_ADDR});
                        if (mem_if.MEM_WE) begin
                            mem_write(mem_if.MEM_ADDR, mem_if.MEM_WDATA, mem_if.MEM_FUNC3);
                            if (exp_st_q.size() == 0) begin
                                chk("unexpected_store", {1'b1, mem_if.MEM_ADDR}, 64'h0);
                            end else begin
                                e = exp_st_q.pop_front();
                                chk("drain_addr_data", {mem_if.MEM_ADDR, mem_if.MEM_WDATA}, {e.addr, e.data});
                                chk("drain_func3", {61'h0, mem_if.MEM_FUNC3}, {61'h0, e.f3});
                            end
                            $display("mem write addr=0x%08h data=0x%08h f3=%0d",
                                     mem_if.MEM_ADDR, mem_if.MEM_WDATA, mem_if.MEM_FUNC3);
                        end else begin
                            mem_if.MEM_RDATA = mem_words.exists(mem_if.MEM_ADDR[31:2])
                                               ? mem_words[mem_if.MEM_ADDR[31:2]] : 32'h0;
                            $display("mem read  addr=0x%08h data=0x%08h", mem_if.MEM_ADDR, mem_if.MEM_RDATA);
                        end
                    end
                end
            end
        end
    end

    task automatic drive_op(input vec_t v);
        st_t s;
        rd_en = v.is_load; wr_en = !v.is_load; f3 = v.f3; result = v.addr; rdata2 = v.data;
        rs2 = v.rs2; wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
        if (v.is_load) begin
            exp_ld_q.push_back(v.exp);
        end else begin
            s.addr = v.addr; s.data = v.exp; s.f3 = v.f3;
            exp_st_q.push_back(s);
        end
    endtask

    task automatic finish_op(input vec_t v, output int busy_cycles);
        int          n;
        logic [31:0] e;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        busy_cycles = n;
        if (v.is_load) begin
            e = exp_ld_q.pop_front();
            if (n >= 300) chk("load_busy_timeout", 64'(n), 64'h0);
            else          chk("load_data", read_data, e);
        end else if (n >= 300) begin
            chk("store_busy_timeout", 64'(n), 64'h0);
        end
        $display("op %s f3=%0d addr=0x%08h busy_cycles=%0d read_data=0x%08h count=%0d",
                 v.is_load ? "LOAD " : "STORE", v.f3, v.addr, n, read_data, sb_count);
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0; wb_en = 1'b0;
    endtask

    task automatic issue(input vec_t v);
        int bc;
        drive_op(v);
        finish_op(v, bc);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while ((sb_count != 3'd0 || mem_if.MEM_REQ) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, {61'h0, sb_count}, 64'h0);
        chk({name, "_queue"}, 64'(exp_st_q.size()), 64'h0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [15];

    initial begin
        int   bc;
        vec_t v;
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bc;
        vec_t        v;
        logic [32:0] op0, op1;

        vecs[0]  = mk(0, 3'b010, 32'h500, 32'h11111111, 5'd5, 1, 5'd5, 32'hCAFEF00D, 32'hCAFEF00D);
        vecs[1]  = mk(0, 3'b010, 32'h504, 32'h22222222, 5'd0, 1, 5'd0, 32'hDEAD0000, 32'h22222222);
        vecs[2]  = mk(0, 3'b010, 32'h508, 32'h33333333, 5'd6, 0, 5'd6, 32'h99999999, 32'h33333333);
        vecs[3]  = mk(0, 3'b010, 32'h50C, 32'h00000044, 5'd7, 1, 5'd8, 32'h77777777, 32'h00000044);
        vecs[4]  = mk(1, 3'b000, 32'h303, 0, 0, 0, 0, 0, 32'hFFFFFF80);
        vecs[5]  = mk(1, 3'b100, 32'h303, 0, 0, 0, 0, 0, 32'h00000080);
        vecs[6]  = mk(1, 3'b001, 32'h302, 0, 0, 0, 0, 0, 32'hFFFF80FF);
        vecs[7]  = mk(1, 3'b101, 32'h300, 0, 0, 0, 0, 0, 32'h00007F01);
        vecs[8]  = mk(1, 3'b010, 32'h300, 0, 0, 0, 0, 0, 32'h80FF7F01);
        vecs[9]  = mk(1, 3'b000, 32'h300, 0, 0, 0, 0, 0, 32'h00000001);
        vecs[10] = mk(1, 3'b001, 32'h300, 0, 0, 0, 0, 0, 32'h00007F01);
        vecs[11] = mk(1, 3'b100, 32'h301, 0, 0, 0, 0, 0, 32'h0000007F);
        vecs[12] = mk(0, 3'b000, 32'h511, 32'h000000AB, 5'd9, 0, 5'd0, 32'h0, 32'h000000AB);
        vecs[13] = mk(1, 3'b010, 32'h510, 0, 0, 0, 0, 0, 32'h0000AB00);
        vecs[14] = mk(1, 3'b010, 32'h500, 0, 0, 0, 0, 0, 32'hCAFEF00D);

        mem_words[30'(32'h300 >> 2)] = 32'h80FF7F01;
        mem_words[30'(32'h200 >> 2)] = 32'hA5A55A5A;

        // Reset: a pending load must not raise busywait while reset is held.
        rst_n = 1'b0; rd_en = 1'b1; wr_en = 1'b0; wb_en = 1'b0; f3 = '0; result = '0;
        rdata2 = '0; rs2 = '0; wb_addr = '0; wb_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_req", {63'h0, mem_if.MEM_REQ}, 64'h0);
        chk("rst_we", {63'h0, mem_if.MEM_WE}, 64'h0);
        chk("rst_addr", mem_if.MEM_ADDR, 64'h0);
        chk("rst_wdata", mem_if.MEM_WDATA, 64'h0);
        chk("rst_func3", {61'h0, mem_if.MEM_FUNC3}, 64'h0);
        chk("rst_count", {61'h0, sb_count}, 64'h0);
        chk("rst_read_data", read_data, 64'h0);
        rd_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Load issues ahead of the older buffered store.
        ops_q.delete();
        ack_lat = 2;
        issue(mk(0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd3, 0, 5'd0, 32'h0, 32'hDEADBEEF));
        issue(mk(1, 3'b010, 32'h200, 0, 0, 0, 0, 0, 32'hA5A55A5A));
        wait_empty("b_drain");
        op0 = (ops_q.size() > 0) ? ops_q[0] : 33'h0;
        op1 = (ops_q.size() > 1) ? ops_q[1] : 33'h0;
        chk("b_nops", 64'(ops_q.size()), 64'd2);
        chk("b_first_read", {31'h0, op0}, {31'h0, 1'b0, 32'h200});
        chk("b_then_write", {31'h0, op1}, {31'h0, 1'b1, 32'h100});

        // Vector table: forwarding, extension, hazard stall on a sub-word store.
        ack_lat = 1;
        for (int i = 0; i < 15; i++) issue(vecs[i]);
        wait_empty("c_drain");

        // Full buffer: fifth store stalls until the first drain ack.
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(mk(0, 3'b010, 32'h600 + 32'(4 * i), 32'hA0000000 + 32'(i), 5'd4, 0, 5'd0, 0, 32'hA0000000 + 32'(i)));
        v = mk(0, 3'b010, 32'h610, 32'hA0000004, 5'd4, 0, 5'd0, 0, 32'hA0000004);
        drive_op(v);
        @(negedge clk);
        chk("d_busy", {63'h0, busy}, 64'h1);
        chk("d_count", {61'h0, sb_count}, 64'd4);
        chk("d_req", {63'h0, mem_if.MEM_REQ}, 64'h1);
        chk("d_addr", mem_if.MEM_ADDR, 64'h600);
        repeat (3) @(negedge clk);
        chk("d_busy_hold", {63'h0, busy}, 64'h1);
        chk("d_count_hold", {61'h0, sb_count}, 64'd4);
        ack_en = 1'b1;
        finish_op(v, bc);
        wait_empty("d_drain");

        // Load hitting a buffered SW at the identical address.
        ops_q.delete();
        ack_lat = 3;
        issue(mk(0, 3'b010, 32'h40, 32'h12345678, 5'd2, 0, 5'd0, 0, 32'h12345678));
        v = mk(1, 3'b010, 32'h40, 0, 0, 0, 0, 0, 32'h12345678);
        drive_op(v);
        finish_op(v, bc);
        wait_empty("e_drain");
        op0 = (ops_q.size() > 0) ? ops_q[0] : 33'h0;
        op1 = (ops_q.size() > 1) ? ops_q[1] : 33'h0;
        chk("e_first_write", {31'h0, op0}, {31'h0, 1'b1, 32'h40});
`ifdef MEM_STAGE_SB_BYPASS_EN
        chk("e_bypass_busy", 64'(bc), 64'd1);
        chk("e_nops", 64'(ops_q.size()), 64'd1);
`else
        chk("e_nops", 64'(ops_q.size()), 64'd2);
        chk("e_then_read", {31'h0, op1}, {31'h0, 1'b0, 32'h40});
`endif

        // Reset in the middle of a drain with three entries buffered.
        ack_en = 1'b0;
        ack_lat = 1;
        for (int i = 0; i < 3; i++)
            issue(mk(0, 3'b010, 32'h700 + 32'(4 * i), 32'hB0000000 + 32'(i), 5'd4, 0, 5'd0, 0, 32'hB0000000 + 32'(i)));
        @(negedge clk);
        chk("f_count", {61'h0, sb_count}, 64'd3);
        chk("f_req", {63'h0, mem_if.MEM_REQ}, 64'h1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("f_rst_req", {63'h0, mem_if.MEM_REQ}, 64'h0);
        chk("f_rst_count", {61'h0, sb_count}, 64'h0);
        exp_st_q.delete();
        rst_n = 1'b1;
        resp_manual = 1'b1;
        mem_if.MEM_ACK = 1'b1;
        @(negedge clk);
        mem_if.MEM_ACK = 1'b0;
        @(negedge clk);
        chk("f_late_req", {63'h0, mem_if.MEM_REQ}, 64'h0);
        chk("f_late_count", {61'h0, sb_count}, 64'h0);
        chk("f_late_read_data", read_data, 64'h0);
        resp_manual = 1'b0;
        ack_en = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_stage_sb.md
MEM_STAGE_SB -- requirements
Module: mem_stage_sb

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning): XLEN, 32, data/address width; SB_DEPTH, 4, store-buffer entries (power of two, >=2).
REQ-002 CLK  in  1  the single clock.
REQ-003 RESET  in  1  synchronous, active-low reset, sampled on the rising CLK edge.
REQ-004 MEM_READ_EN_EXMEM / MEM_WRITE_EN_EXMEM  in  1 each  load / store request from EX/MEM (mutually exclusive).
REQ-005 FUNC3_EXMEM  in  3  RV32 width code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-006 RESULT  in  XLEN  ALU result, the byte address.
REQ-007 REG_DATA_2_EXMEM  in  XLEN  store data; RS2_ADDR_EXMEM  in  5  its source register.
REQ-008 REG_WRITE_EN_WB  in  1, REG_WRITE_ADDR_WB  in  5, WB_DATA  in  XLEN  write-back forwarding source.
REQ-009 MEM_REQ  out  1, MEM_WE  out  1, MEM_ADDR  out  XLEN, MEM_WDATA  out  XLEN, MEM_FUNC3  out  3  memory request.
REQ-010 MEM_RDATA  in  XLEN, MEM_ACK  in  1  memory response.
REQ-011 READ_DATA  out  XLEN  extended load result; MEM_BUSYWAIT  out  1  pipeline stall; SB_COUNT  out  log2(SB_DEPTH)+1  occupied entries.

Function
REQ-012 Store data SHALL be WB_DATA when REG_WRITE_EN_WB=1, REG_WRITE_ADDR_WB==RS2_ADDR_EXMEM and RS2_ADDR_EXMEM!=0, else REG_DATA_2_EXMEM.
REQ-013 A store with SB_COUNT<SB_DEPTH at the clock edge SHALL enqueue {RESULT, data, FUNC3_EXMEM} at that edge, MEM_BUSYWAIT=0 in its cycle.
REQ-014 A store with SB_COUNT==SB_DEPTH SHALL hold MEM_BUSYWAIT=1 and not enqueue, even if an entry drains that same edge; it enqueues on the first edge with a free slot.
REQ-015 The buffer SHALL be FIFO; pointers wrap modulo SB_DEPTH; SB_COUNT increments on enqueue, decrements on drain, unchanged on both in one edge.
REQ-016 FSM states: IDLE, DRAIN, LOAD. IDLE->LOAD when a load is pending and not hazard-blocked; else IDLE->DRAIN when SB_COUNT>0; DRAIN->IDLE and LOAD->IDLE on the edge MEM_ACK=1 is sampled.
REQ-017 A pending load SHALL take priority over draining when leaving IDLE; an in-progress DRAIN is never aborted.
REQ-018 MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_FUNC3 SHALL be registered and stable from entry to DRAIN/LOAD until the ACK edge; MEM_REQ deasserts the cycle after ACK.
REQ-019 Load hazard: a load whose RESULT[XLEN-1:2] matches any valid buffer entry SHALL not issue until no match remains.
REQ-020 MEM_BUSYWAIT SHALL be 1 during a load from its first cycle until the cycle after the load ACK, when READ_DATA holds the result and MEM_BUSYWAIT=0.
REQ-021 READ_DATA SHALL be registered: byte/half selected by RESULT[1:0] (half by RESULT[1]), sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW.
REQ-022 Misaligned addresses SHALL be passed through unmodified; alignment is not checked.
REQ-023 MEM_ACK outside DRAIN/LOAD SHALL be ignored.

Reset
REQ-024 With RESET=0 at an edge: FSM=IDLE, buffer pointers and SB_COUNT=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, MEM_FUNC3=0, READ_DATA=0; MEM_BUSYWAIT=0 while RESET=0.
REQ-025 Reset mid-transaction SHALL drop the request immediately and discard buffered stores; a late ACK after reset is ignored.

Configuration
REQ-026 Macro MEM_STAGE_SB_BYPASS_EN defined: a hazard load (REQ-019) whose youngest matching entry is SW with identical RESULT SHALL take extended data from that entry, load into READ_DATA at the next edge without a memory request (one busy cycle); other hazards stall as REQ-019.
REQ-027 Macro undefined: all hazard loads stall per REQ-019; no bypass logic is synthesised.

Verification
REQ-028 SW 0xDEADBEEF @0x100, then LW @0x200, mem ACK in 2 cycles -> load issued before drain, READ_DATA=mem word, store drains afterwards.
REQ-029 SB_DEPTH=4, five back-to-back SW with MEM_ACK held 0 -> SB_COUNT=4, MEM_BUSYWAIT=1 on 5th store until first ACK, then enqueues.
REQ-030 SW 0x12345678 @0x40 then LW @0x40 -> bypass on: READ_DATA=0x12345678, MEM_REQ never issued for the load; bypass off: stall until drained, then memory read.
REQ-031 MEM_RDATA=0x80FF7F01, LB @+3 -> 0xFFFFFF80; LBU @+3 -> 0x00000080; LH @+2 -> 0xFFFF80FF; LHU @+0 -> 0x00007F01.
REQ-032 WB writes x5=0xCAFEF00D while SW rs2=x5 in MEM -> buffered data 0xCAFEF00D; RS2=x0 -> REG_DATA_2_EXMEM used.
REQ-033 RESET=0 during DRAIN with 3 entries -> next cycle MEM_REQ=0, SB_COUNT=0, late ACK ignored.
